reg_wr_port_ctrl: RTL

//   Sequences and arbitrates the single register-file write port between the ALU (result) and the

---
 rtl/reg_wr_port_ctrl_if.sv | 43 ++++
 rtl/reg_wr_port_ctrl.sv | 135 +++++++++++++
 2 files changed

// File: rtl/reg_wr_port_ctrl_if.sv
// Purpose: groups the request/ack handshakes of the ALU and decoder, the
//          register-file stall, the register-file write port outputs and the
//          conflict counter of reg_wr_port_ctrl into one bundle.
// Ports (signals):
//   alu_req/alu_adr/result/alu_ack         ALU write request handshake
//   dec_req/dec_adr/literal_adr/dec_ack    decoder write request handshake
//   wr_stall                               register file cannot take a write
//   reg_we/reg_wr_adr/reg_val              registered write port
//   sel_reg_in_alu_decoder                 1 = ALU, 0 = decoder source
//   conflict_cnt                           saturating count of conflict cycles
// Modports: master = requesters/register file side, slave = controller side.
interface reg_wr_port_ctrl_if #(
    parameter int DataWidth = 8,
    parameter int AdrWidth  = 4,
    parameter int CntWidth  = 8
);
    logic                 alu_req;
    logic [AdrWidth-1:0]  alu_adr;
    logic [DataWidth-1:0] result;
    logic                 alu_ack;
    logic                 dec_req;
    logic [AdrWidth-1:0]  dec_adr;
    logic [DataWidth-1:0] literal_adr;
    logic                 dec_ack;
    logic                 wr_stall;
    logic                 reg_we;
    logic [AdrWidth-1:0]  reg_wr_adr;
    logic [DataWidth-1:0] reg_val;
    logic                 sel_reg_in_alu_decoder;
    logic [CntWidth-1:0]  conflict_cnt;

    modport master (
        output alu_req, alu_adr, result, dec_req, dec_adr, literal_adr, wr_stall,
        input  alu_ack, dec_ack, reg_we, reg_wr_adr, reg_val,
               sel_reg_in_alu_decoder, conflict_cnt
    );

    modport slave (
        input  alu_req, alu_adr, result, dec_req, dec_adr, literal_adr, wr_stall,
        output alu_ack, dec_ack, reg_we, reg_wr_adr, reg_val,
               sel_reg_in_alu_decoder, conflict_cnt
    );
endinterface

// File: rtl/reg_wr_port_ctrl.sv
// Purpose: arbitrates the single register-file write port between the ALU
//          result and the decoder literal, registers the winning address and
//          data, drives a write strobe and source select, and holds the port
//          while the register file stalls.
// Ports:
//   clk    system clock, rising edge
//   reset  synchronous, active-high reset
//   bus    reg_wr_port_ctrl_if.slave: request/ack handshakes, wr_stall,
//          reg_we/reg_wr_adr/reg_val, sel_reg_in_alu_decoder, conflict_cnt
// Configuration macro: RR_ARB_EN
//   defined   -> round-robin on simultaneous requests (first conflict to ALU)
//   undefined -> fixed priority, ALU wins every conflict
//
// state | meaning
// IDLE  | no write on the port, reg_we low
// WRITE | write presented on the port, reg_we high (held while stalled)
module reg_wr_port_ctrl #(
    parameter int DataWidth = 8,
    parameter int AdrWidth  = 4,
    parameter int CntWidth  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    reg_wr_port_ctrl_if.slave     bus
);

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic                 reg_we_q, reg_we_d;
    logic [AdrWidth-1:0]  reg_wr_adr_q, reg_wr_adr_d;
    logic [DataWidth-1:0] reg_val_q, reg_val_d;
    logic                 sel_q, sel_d;
    logic [CntWidth-1:0]  conflict_cnt_q, conflict_cnt_d;
    // 1 = ALU was granted last, 0 = decoder
    logic                 last_grant_q, last_grant_d;

    logic accept_ok;
    logic alu_wins;
    logic alu_ack;
    logic dec_ack;

`ifdef RR_ARB_EN
    // Conflict goes to whoever did not win last; reset value (decoder) makes
    // the first conflict go to the ALU.
    assign alu_wins = ~last_grant_q;
`else
    assign alu_wins = 1'b1;
    logic unused_last_grant;
    assign unused_last_grant = last_grant_q;
`endif

    always_comb begin
        state_d        = state_q;
        reg_we_d       = reg_we_q;
        reg_wr_adr_d   = reg_wr_adr_q;
        reg_val_d      = reg_val_q;
        sel_d          = sel_q;
        conflict_cnt_d = conflict_cnt_q;
        last_grant_d   = last_grant_q;
        alu_ack        = 1'b0;
        dec_ack        = 1'b0;

        // A stall only matters once a write is on the port.
        accept_ok = ~reset & ((state_q == IDLE) | ((state_q == WRITE) & ~bus.wr_stall));

        if (accept_ok) begin
            if (bus.alu_req & (~bus.dec_req | alu_wins)) begin
                alu_ack = 1'b1;
            end else if (bus.dec_req) begin
                dec_ack = 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                if (alu_ack | dec_ack) state_d = WRITE;
            end
            WRITE: begin
                if (~bus.wr_stall & ~(alu_ack | dec_ack)) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        reg_we_d = (state_d == WRITE);

        if (alu_ack) begin
            reg_wr_adr_d = bus.alu_adr;
            reg_val_d    = bus.result;
            sel_d        = 1'b1;
            last_grant_d = 1'b1;
        end else if (dec_ack) begin
            reg_wr_adr_d = bus.dec_adr;
            reg_val_d    = bus.literal_adr;
            sel_d        = 1'b0;
            last_grant_d = 1'b0;
        end

        if (bus.alu_req & bus.dec_req & accept_ok & (conflict_cnt_q != '1)) begin
            conflict_cnt_d = conflict_cnt_q + CntWidth'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            reg_we_q       <= 1'b0;
            reg_wr_adr_q   <= '0;
            reg_val_q      <= '0;
            sel_q          <= 1'b0;
            conflict_cnt_q <= '0;
            last_grant_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            reg_we_q       <= reg_we_d;
            reg_wr_adr_q   <= reg_wr_adr_d;
            reg_val_q      <= reg_val_d;
            sel_q          <= sel_d;
            conflict_cnt_q <= conflict_cnt_d;
            last_grant_q   <= last_grant_d;
        end
    end

    assign bus.alu_ack                = alu_ack;
    assign bus.dec_ack                = dec_ack;
    assign bus.reg_we                 = reg_we_q;
    assign bus.reg_wr_adr             = reg_wr_adr_q;
    assign bus.reg_val                = reg_val_q;
    assign bus.sel_reg_in_alu_decoder = sel_q;
    assign bus.conflict_cnt           = conflict_cnt_q;

endmodule
